fpnew_divsqrt_iter_core: RTL



---
 rtl/fpnew_divsqrt_iter_core_pkg.sv | 23 ++
 rtl/fpnew_divsqrt_iter_step.sv | 33 +++
 rtl/fpnew_divsqrt_iter_core.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fpnew_divsqrt_iter_core_pkg.sv
// Shared types and latency helper for the iterative radix-2 divide/sqrt engine.
package fpnew_divsqrt_iter_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } divsqrt_iter_state_e;

  typedef enum logic {
    ITER_DIV  = 1'b0,
    ITER_SQRT = 1'b1
  } divsqrt_iter_op_e;

  // Edges from the accepting edge to the edge that raises done_o.
  function automatic int unsigned divsqrt_iter_cycles(input int unsigned width,
                                                      input bit          radix4);
    int unsigned res_w;
    res_w = width + 2;
    return radix4 ? ((res_w + 1) / 2) + 1 : res_w + 1;
  endfunction

endpackage

// File: rtl/fpnew_divsqrt_iter_step.sv
// One combinational radix-2 trial-subtract step, shared by divide and sqrt.
module fpnew_divsqrt_iter_step
  import fpnew_divsqrt_iter_core_pkg::*;
#(
  parameter int unsigned RW = 13
) (
  input  logic [RW-1:0]    i_rem,
  input  logic [RW-1:0]    i_den,
  input  logic [1:0]       i_rad,
  input  divsqrt_iter_op_e i_op,
  output logic [RW-1:0]    o_rem,
  output logic             o_bit
);

  logic [RW-1:0] w_trial;
  logic [RW-1:0] w_sub;
  logic [RW-1:0] w_diff;

  // Sqrt brings in the next radicand pair and tries (root << 2) | 1;
  // divide tries the divisor and doubles the remainder afterwards.
  always_comb begin
    w_trial = i_rem;
    w_sub   = i_den;
    if (i_op == ITER_SQRT) begin
      w_trial = {i_rem[RW-3:0], i_rad};
      w_sub   = {i_den[RW-3:0], 2'b01};
    end
    o_bit  = (w_trial >= w_sub);
    w_diff = o_bit ? (w_trial - w_sub) : w_trial;
    o_rem  = (i_op == ITER_SQRT) ? w_diff : {w_diff[RW-2:0], 1'b0};
  end

endmodule

// File: rtl/fpnew_divsqrt_iter_core.sv
// Iterative mantissa divide/sqrt engine with start/ready/done/kill handshake.
// Optional FPNEW_DIVSQRT_ITER_RADIX4_EN chains two steps per cycle.
module fpnew_divsqrt_iter_core
  import fpnew_divsqrt_iter_core_pkg::*;
#(
  parameter int unsigned WIDTH = 53
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               div_start_i,
  input  logic               sqrt_start_i,
  input  logic [WIDTH-1:0]   op_a_i,
  input  logic [WIDTH-1:0]   op_b_i,
  input  logic               kill_i,
  output logic [WIDTH+1:0]   result_o,
  output logic               sticky_o,
  output logic               ready_o,
  output logic               done_o,
  output logic               busy_o
);

  localparam int unsigned RES_W = WIDTH + 2;
  localparam int unsigned RW    = RES_W + 3;
  localparam int unsigned CNT_W = $clog2(RES_W + 1);
`ifdef FPNEW_DIVSQRT_ITER_RADIX4_EN
  localparam bit RADIX4 = 1'b1;
`else
  localparam bit RADIX4 = 1'b0;
`endif
  localparam int unsigned CNT_LOAD = divsqrt_iter_cycles(WIDTH, RADIX4) - 1;

  divsqrt_iter_state_e r_state, w_next;
  divsqrt_iter_op_e    r_op;
  logic [CNT_W-1:0]    r_cnt;
  logic [RW-1:0]       r_rem;
  logic [WIDTH-1:0]    r_den;
  logic [2*RES_W-1:0]  r_rad;
  logic [RES_W-1:0]    r_q;
  logic                r_div0;
  logic [RES_W-1:0]    r_result;
  logic                r_sticky;

  logic                w_accept;
  logic [RW-1:0]       w_den0, w_rem0, w_rem_nx;
  logic                w_bit0;
  logic [RES_W-1:0]    w_q_nx;
  logic [2*RES_W-1:0]  w_rad_nx;

  assign w_accept = (div_start_i | sqrt_start_i) & ready_o & ~kill_i;
  assign w_den0   = (r_op == ITER_DIV) ? {{(RW-WIDTH){1'b0}}, r_den} : {3'b000, r_q};

  fpnew_divsqrt_iter_step #(.RW(RW)) u_step0 (
    .i_rem (r_rem),
    .i_den (w_den0),
    .i_rad (r_rad[2*RES_W-1 -: 2]),
    .i_op  (r_op),
    .o_rem (w_rem0),
    .o_bit (w_bit0)
  );

`ifdef FPNEW_DIVSQRT_ITER_RADIX4_EN
  logic [RW-1:0] w_den1, w_rem1;
  logic          w_bit1;
  logic          w_two;

  // The second step sees the partial root already extended by the first bit.
  assign w_den1 = (r_op == ITER_DIV) ? {{(RW-WIDTH){1'b0}}, r_den}
                                     : {3'b000, r_q[RES_W-2:0], w_bit0};

  fpnew_divsqrt_iter_step #(.RW(RW)) u_step1 (
    .i_rem (w_rem0),
    .i_den (w_den1),
    .i_rad (r_rad[2*RES_W-3 -: 2]),
    .i_op  (r_op),
    .o_rem (w_rem1),
    .o_bit (w_bit1)
  );

  // Odd result widths leave a single step for the last cycle.
  assign w_two    = (r_cnt != CNT_W'(1)) || ((RES_W % 2) == 0);
  assign w_rem_nx = w_two ? w_rem1 : w_rem0;
  assign w_q_nx   = w_two ? {r_q[RES_W-3:0], w_bit0, w_bit1} : {r_q[RES_W-2:0], w_bit0};
  assign w_rad_nx = w_two ? (r_rad << 4) : (r_rad << 2);
`else
  assign w_rem_nx = w_rem0;
  assign w_q_nx   = {r_q[RES_W-2:0], w_bit0};
  assign w_rad_nx = r_rad << 2;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (kill_i) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_next = ST_BUSY;
        ST_BUSY: if (r_cnt == '0) w_next = ST_DONE;
        ST_DONE: w_next = w_accept ? ST_BUSY : ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o = (r_state == ST_IDLE) || (r_state == ST_DONE);
    busy_o  = (r_state == ST_BUSY) || (r_state == ST_DONE);
    done_o  = (r_state == ST_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_op     <= ITER_DIV;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_den    <= '0;
      r_rad    <= '0;
      r_q      <= '0;
      r_div0   <= 1'b0;
      r_result <= '0;
      r_sticky <= 1'b0;
    end else if (w_accept) begin
      r_op   <= div_start_i ? ITER_DIV : ITER_SQRT;
      r_rem  <= div_start_i ? {{(RW-WIDTH){1'b0}}, op_a_i} : '0;
      r_den  <= op_b_i;
      r_rad  <= {op_a_i, {(WIDTH+4){1'b0}}};
      r_q    <= '0;
      r_div0 <= div_start_i & (op_b_i == '0);
      r_cnt  <= CNT_W'(CNT_LOAD);
    end else if (kill_i) begin
      r_cnt <= '0;
    end else if (r_state == ST_BUSY) begin
      if (r_cnt != '0) begin
        r_rem <= w_rem_nx;
        r_q   <= w_q_nx;
        r_rad <= w_rad_nx;
        r_cnt <= r_cnt - CNT_W'(1);
      end else begin
        r_result <= r_div0 ? '1 : r_q;
        r_sticky <= r_div0 | (r_rem != '0);
      end
    end
  end

  assign result_o = r_result;
  assign sticky_o = r_sticky;

endmodule
